// File: rtl/hd44780_pkg.sv
// Shared encodings, state enum and request payload for the HD44780 4-bit write sequencer.
package hd44780_pkg;

    localparam int unsigned BUS_WIDTH = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 7;

    localparam logic [BYTE_W-1:0] CMD_CLEAR     = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_HOME      = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [ADDR_W-1:0] LINE1_BASE    = 7'h40;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HI_E,
        ST_GAP,
        ST_LO_E,
        ST_WAIT,
        ST_WRAP_HI_E,
        ST_WRAP_GAP,
        ST_WRAP_LO_E,
        ST_WRAP_WAIT
    } seq_state_t;

    typedef struct packed {
        logic              rs;
        logic [BYTE_W-1:0] data;
    } lcd_req_t;

    // Clear (0x01) and home (0x02/0x03) need the long settle time and reset the cursor.
    function automatic logic is_long_cmd(input lcd_req_t r);
        return !r.rs && ((r.data == CMD_CLEAR) || (r.data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/hd44780_delay.sv
// Loadable down-counter shared by every timed sequencer state; done while the count is zero.
module hd44780_delay #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/hd44780_write_sequencer.sv
// Run-time HD44780 4-bit byte scheduler: nibble strobes, post-write waits and automatic line wrap.
module hd44780_write_sequencer
    import hd44780_pkg::*;
#(
    parameter int unsigned EN_HIGH_CYC   = 2,
    parameter int unsigned EN_GAP_CYC    = 2,
    parameter int unsigned CMD_WAIT_CYC  = 20,
    parameter int unsigned LONG_WAIT_CYC = 400,
    parameter int unsigned LINE_LEN      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    input  logic                 i_req_rs,
    input  logic [BYTE_W-1:0]    i_req_data,
    output logic                 o_req_ready,
    output logic                 o_busy,
    output logic                 o_e,
    output logic                 o_rs,
    output logic [BUS_WIDTH-1:0] o_db,
    output logic [ADDR_W-1:0]    o_ddram_addr
);

    localparam int unsigned MAX_A   = (EN_HIGH_CYC > EN_GAP_CYC) ? EN_HIGH_CYC : EN_GAP_CYC;
    localparam int unsigned MAX_B   = (CMD_WAIT_CYC > LONG_WAIT_CYC) ? CMD_WAIT_CYC : LONG_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_HIGH = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(EN_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMD  = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG = CNT_W'(LONG_WAIT_CYC - 1);

    localparam logic [ADDR_W-1:0] WRAP0_ADDR = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W-1:0] WRAP1_ADDR = ADDR_W'(32'h40 + LINE_LEN - 1);
    localparam logic [BYTE_W-1:0] WRAP_TO_L1 = CMD_SET_DDRAM | BYTE_W'(LINE1_BASE);

    seq_state_t            r_state, w_state_nxt;
    lcd_req_t              r_req, w_req_nxt;
    logic                  r_e, w_e_nxt;
    logic                  r_rs, w_rs_nxt;
    logic [BUS_WIDTH-1:0]  r_db, w_db_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic                  r_wrap, w_wrap_nxt;
    logic [BYTE_W-1:0]     r_wrap_byte, w_wrap_byte_nxt;
    logic                  r_ready;
    logic                  r_busy;
    logic                  w_load;
    logic [CNT_W-1:0]      w_load_val;
    logic                  w_done;

    hd44780_delay #(.CNT_W(CNT_W)) u_delay (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done_c   (w_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_db        <= '0;
            r_addr      <= '0;
            r_wrap      <= 1'b0;
            r_wrap_byte <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_e         <= w_e_nxt;
            r_rs        <= w_rs_nxt;
            r_db        <= w_db_nxt;
            r_addr      <= w_addr_nxt;
            r_wrap      <= w_wrap_nxt;
            r_wrap_byte <= w_wrap_byte_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next state, next bus values and shadow address; bus outputs are registered from these.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_rs_nxt        = r_rs;
        w_db_nxt        = r_db;
        w_addr_nxt      = r_addr;
        w_wrap_nxt      = r_wrap;
        w_wrap_byte_nxt = r_wrap_byte;
        w_load          = 1'b0;
        w_load_val      = '0;
        w_e_nxt         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && r_ready) begin
                    w_state_nxt = ST_HI_E;
                    w_req_nxt   = '{rs: i_req_rs, data: i_req_data};
                    w_rs_nxt    = i_req_rs;
                    w_db_nxt    = i_req_data[7:4];
                    w_load      = 1'b1;
                    w_load_val  = LD_HIGH;
                end
            end
            ST_HI_E: begin
                if (w_done) begin
                    w_state_nxt = ST_GAP;
                    w_db_nxt    = r_req.data[3:0];
                    w_load      = 1'b1;
                    w_load_val  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (w_done) begin
                    w_state_nxt = ST_LO_E;
                    w_load      = 1'b1;
                    w_load_val  = LD_HIGH;
                end
            end
            ST_LO_E: begin
                if (w_done) begin
                    w_state_nxt = ST_WAIT;
                    w_load      = 1'b1;
                    w_load_val  = is_long_cmd(r_req) ? LD_LONG : LD_CMD;
                    w_wrap_nxt  = 1'b0;
                    // Shadow cursor lands on the first WAIT cycle.
                    if (r_req.rs) begin
                        if (r_addr == WRAP0_ADDR) begin
                            w_addr_nxt      = LINE1_BASE;
                            w_wrap_nxt      = 1'b1;
                            w_wrap_byte_nxt = WRAP_TO_L1;
                        end else if (r_addr == WRAP1_ADDR) begin
                            w_addr_nxt      = '0;
                            w_wrap_nxt      = 1'b1;
                            w_wrap_byte_nxt = CMD_SET_DDRAM;
                        end else if (r_addr != '1) begin
                            w_addr_nxt = r_addr + ADDR_W'(1);
                        end
                    end else if (is_long_cmd(r_req)) begin
                        w_addr_nxt = '0;
                    end else if (r_req.data[7]) begin
                        w_addr_nxt = r_req.data[6:0];
                    end
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    if (r_wrap) begin
                        w_state_nxt = ST_WRAP_HI_E;
                        w_wrap_nxt  = 1'b0;
                        w_rs_nxt    = 1'b0;
                        w_db_nxt    = r_wrap_byte[7:4];
                        w_load      = 1'b1;
                        w_load_val  = LD_HIGH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WRAP_HI_E: begin
                if (w_done) begin
                    w_state_nxt = ST_WRAP_GAP;
                    w_db_nxt    = r_wrap_byte[3:0];
                    w_load      = 1'b1;
                    w_load_val  = LD_GAP;
                end
            end
            ST_WRAP_GAP: begin
                if (w_done) begin
                    w_state_nxt = ST_WRAP_LO_E;
                    w_load      = 1'b1;
                    w_load_val  = LD_HIGH;
                end
            end
            ST_WRAP_LO_E: begin
                if (w_done) begin
                    w_state_nxt = ST_WRAP_WAIT;
                    w_load      = 1'b1;
                    w_load_val  = LD_CMD;
                end
            end
            ST_WRAP_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_e_nxt = (w_state_nxt == ST_HI_E) || (w_state_nxt == ST_LO_E) ||
                  (w_state_nxt == ST_WRAP_HI_E) || (w_state_nxt == ST_WRAP_LO_E);
    end

    assign o_req_ready  = r_ready;
    assign o_busy       = r_busy;
    assign o_e          = r_e;
    assign o_rs         = r_rs;
    assign o_db         = r_db;
    assign o_ddram_addr = r_addr;

endmodule

// File: tb/tb_hd44780_write_sequencer.sv
// Randomized self-checking bench: observed E pulses, gaps, latency and cursor vs. a transaction-level model.
module tb_hd44780_write_sequencer;

    localparam int H    = 2;
    localparam int G    = 2;
    localparam int CMD  = 20;
    localparam int LONG = 400;
    localparam int LL   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_req_valid = 1'b0;
    logic       i_req_rs = 1'b0;
    logic [7:0] i_req_data = 8'h00;
    logic       o_req_ready, o_busy, o_e, o_rs;
    logic [3:0] o_db;
    logic [6:0] o_ddram_addr;

    int n_checks = 0;
    int n_errors = 0;
    int m_addr   = 0;

    hd44780_write_sequencer #(
        .EN_HIGH_CYC(H), .EN_GAP_CYC(G), .CMD_WAIT_CYC(CMD),
        .LONG_WAIT_CYC(LONG), .LINE_LEN(LL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(i_req_valid), .i_req_rs(i_req_rs),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_busy(o_busy),
        .o_e(o_e), .o_rs(o_rs), .o_db(o_db), .o_ddram_addr(o_ddram_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends one byte (caller sits on a negedge) and checks every strobe it produces.
    task automatic send(input logic rs_i, input logic [7:0] d, input bit noise);
        int cyc, np, lo_len, exp_n, wait_len, exp_lat, wb;
        int prs[4], pdb[4], plen[4], plow[4], fdb[4];
        int ers[4], edb[4], elow[4];
        bit wrap;
        logic pe;

        cyc = 0;
        while (o_req_ready !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_send", int'(o_req_ready), 1);
        i_req_valid = 1'b1;
        i_req_rs    = rs_i;
        i_req_data  = d;
        @(posedge clk);
        #1;
        if (noise) begin
            i_req_data = 8'($urandom);
            i_req_rs   = 1'($urandom);
        end else begin
            i_req_valid = 1'b0;
        end

        // Transaction-level model of the expected bus activity and cursor.
        wait_len = (rs_i == 1'b0 && d >= 8'd1 && d <= 8'd3) ? LONG : CMD;
        wrap = 1'b0;
        wb   = 0;
        if (rs_i) begin
            if (m_addr == LL - 1) begin
                m_addr = 'h40; wrap = 1'b1; wb = 'hC0;
            end else if (m_addr == 'h40 + LL - 1) begin
                m_addr = 0; wrap = 1'b1; wb = 'h80;
            end else if (m_addr < 127) begin
                m_addr = m_addr + 1;
            end
        end else if (d >= 8'd1 && d <= 8'd3) begin
            m_addr = 0;
        end else if (d >= 8'h80) begin
            m_addr = int'(d) - 'h80;
        end
        exp_n   = wrap ? 4 : 2;
        exp_lat = 1 + 2 * H + G + wait_len + (wrap ? (2 * H + G + CMD) : 0);
        ers  = '{int'(rs_i), int'(rs_i), 0, 0};
        edb  = '{int'(d) / 16, int'(d) % 16, wb / 16, wb % 16};
        elow = '{0, G, wait_len, G};

        np = 0; lo_len = 0; cyc = 0; pe = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("ready_drop", int'(o_req_ready), 0);
            if (o_e) begin
                if (!pe) begin
                    if (np < 4) begin
                        prs[np] = int'(o_rs); pdb[np] = int'(o_db);
                        plen[np] = 0; plow[np] = lo_len;
                    end
                    np++;
                end
                if (np <= 4) plen[np-1]++;
                lo_len = 0;
            end else begin
                if (pe && np <= 4) fdb[np-1] = int'(o_db);
                lo_len++;
            end
            pe = o_e;
            if (noise) begin
                i_req_data = 8'($urandom);
                i_req_rs   = 1'($urandom);
            end
        end while (o_req_ready !== 1'b1 && cyc < 3000);
        i_req_valid = 1'b0;

        check("latency", cyc, exp_lat);
        check("pulse_count", np, exp_n);
        for (int i = 0; i < exp_n && i < np && i < 4; i++) begin
            check($sformatf("p%0d_rs", i), prs[i], ers[i]);
            check($sformatf("p%0d_db", i), pdb[i], edb[i]);
            check($sformatf("p%0d_len", i), plen[i], H);
            check($sformatf("p%0d_low_before", i), plow[i], elow[i]);
            check($sformatf("p%0d_db_after_fall", i), fdb[i], edb[i | 1]);
        end
        check("ddram_addr", int'(o_ddram_addr), m_addr);
        check("busy_idle", int'(o_busy), 0);
    endtask

    initial begin
        int sel, pick;
        int win[8] = '{'h0E, 'h0F, 'h4E, 'h4F, 'h7E, 'h7F, 'h20, 'h00};
        logic rs_r;
        logic [7:0] d_r;

        repeat (3) @(negedge clk);
        check("rst_e", int'(o_e), 0);
        check("rst_rs", int'(o_rs), 0);
        check("rst_db", int'(o_db), 0);
        check("rst_addr", int'(o_ddram_addr), 0);
        check("rst_ready", int'(o_req_ready), 0);
        check("rst_busy", int'(o_busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", int'(o_req_ready), 1);

        send(1'b1, 8'h41, 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h8F, 1'b0);
        send(1'b1, 8'h5A, 1'b0);
        send(1'b0, 8'hCF, 1'b0);
        send(1'b1, 8'h21, 1'b0);
        send(1'b1, 8'h62, 1'b1);
        send(1'b0, 8'h03, 1'b1);
        send(1'b0, 8'hFE, 1'b1);
        send(1'b1, 8'h33, 1'b1);
        send(1'b1, 8'h34, 1'b0);

        // Abort during LO_E: async clear of the bus and cursor, then a clean restart.
        send(1'b0, 8'h85, 1'b0);
        i_req_valid = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h77;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("lo_e_before_rst", int'(o_e), 1);
        check("lo_e_db", int'(o_db), 7);
        #2 rst = 1'b1;
        #1;
        check("abort_e", int'(o_e), 0);
        check("abort_rs", int'(o_rs), 0);
        check("abort_db", int'(o_db), 0);
        check("abort_addr", int'(o_ddram_addr), 0);
        check("abort_ready", int'(o_req_ready), 0);
        m_addr = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", int'(o_req_ready), 1);
        send(1'b1, 8'h30, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 6) begin
                pick = $urandom_range(0, 7);
                rs_r = 1'b0; d_r = 8'h80 | 8'(win[pick]);
            end else if (sel == 7) begin
                rs_r = 1'b0; d_r = 8'($urandom_range(1, 3));
            end else if (sel == 8) begin
                rs_r = 1'b0; d_r = 8'($urandom_range(4, 127));
            end else begin
                rs_r = 1'b1; d_r = 8'($urandom);
            end
            send(rs_r, d_r, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
